// File: rtl/io_port.sv
// Byte-wide I/O port: CPU output strobes fill a TX FIFO drained over valid/ready,
// and an RX FIFO filled over valid/ready is read onto the CPU bus by the input strobe.
module io_port #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNoe,
    input  logic       i_ctrlWrOut,
    input  logic       i_ctrlInNoe,
    output logic [7:0] o_txData,
    output logic       o_txValid,
    input  logic       i_txReady,
    input  logic [7:0] i_rxData,
    input  logic       i_rxValid,
    output logic       o_rxReady,
    output logic       o_txFull,
    output logic       o_rxEmpty,
    output logic       o_txOverflow,
    output logic       o_rxUnderflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);

    logic [PW-1:0] txRd, txWr, txCount;
    logic [PW-1:0] rxRd, rxWr, rxCount;
    logic [7:0]    txMem [DEPTH];
    logic [7:0]    rxMem [DEPTH];
    logic          rxEnable;
    logic          txPush, txPop, rxPush, rxPop, rxUnder;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both high; ready never depends on valid, valid never waits on ready.
    assign txPop   = o_txValid & i_txReady;
    assign txPush  = i_ctrlWrOut & ((txCount != FULL_COUNT) | txPop);
    assign rxPush  = i_rxValid & o_rxReady;
    assign rxPop   = ~i_ctrlInNoe & (rxCount != '0);
    assign rxUnder = ~i_ctrlInNoe & (rxCount == '0);

    assign o_busNoe      = i_ctrlInNoe;
    assign o_txValid     = (txCount != '0);
    assign o_txFull      = (txCount == FULL_COUNT);
    assign o_rxEmpty     = (rxCount == '0);
    assign o_rxReady     = rxEnable & (rxCount != FULL_COUNT);
    assign o_txData      = o_txValid ? txMem[txRd[AW-1:0]] : 8'h00;
    assign o_bus         = o_rxEmpty ? 8'h00 : rxMem[rxRd[AW-1:0]];

    // rxEnable holds rxReady low while reset is asserted and for the release cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rxEnable <= 1'b0;
        end else begin
            rxEnable <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            txRd         <= '0;
            txWr         <= '0;
            txCount      <= '0;
            o_txOverflow <= 1'b0;
        end else begin
            if (txPop) begin
                txRd <= nextPtr(txRd);
            end
            if (txPush) begin
                txWr <= nextPtr(txWr);
            end
            case ({txPush, txPop})
                2'b10:   txCount <= txCount + PW'(1);
                2'b01:   txCount <= txCount - PW'(1);
                default: txCount <= txCount;
            endcase
            if (i_ctrlWrOut && !txPush) begin
                o_txOverflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rxRd          <= '0;
            rxWr          <= '0;
            rxCount       <= '0;
            o_rxUnderflow <= 1'b0;
        end else begin
            if (rxPop) begin
                rxRd <= nextPtr(rxRd);
            end
            if (rxPush) begin
                rxWr <= nextPtr(rxWr);
            end
            case ({rxPush, rxPop})
                2'b10:   rxCount <= rxCount + PW'(1);
                2'b01:   rxCount <= rxCount - PW'(1);
                default: rxCount <= rxCount;
            endcase
            if (rxUnder) begin
                o_rxUnderflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the counts decide what is visible.
    always_ff @(posedge i_clk) begin
        if (txPush) begin
            txMem[txWr[AW-1:0]] <= i_bus;
        end
        if (rxPush) begin
            rxMem[rxWr[AW-1:0]] <= i_rxData;
        end
    end
endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed scenarios then random traffic, every cycle compared
// against a queue-based model of both FIFOs and the sticky flags.
module tb_io_port;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus, busOut, txData, rxData;
    logic       busNoe, wrOut, inNoe, txValid, txReady, rxValid, rxReady;
    logic       txFull, rxEmpty, txOverflow, rxUnderflow;

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] txExpQ[$];
    logic [7:0] rxExpQ[$];
    logic       expTxOverflow, expRxUnderflow, expRxEnable;

    io_port #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(reset), .i_bus(bus), .o_bus(busOut), .o_busNoe(busNoe),
        .i_ctrlWrOut(wrOut), .i_ctrlInNoe(inNoe), .o_txData(txData), .o_txValid(txValid),
        .i_txReady(txReady), .i_rxData(rxData), .i_rxValid(rxValid), .o_rxReady(rxReady),
        .o_txFull(txFull), .o_rxEmpty(rxEmpty), .o_txOverflow(txOverflow),
        .o_rxUnderflow(rxUnderflow)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        txExpQ.delete();
        rxExpQ.delete();
        expTxOverflow  = 1'b0;
        expRxUnderflow = 1'b0;
        expRxEnable    = 1'b0;
    endtask

    task automatic checkOutputs();
        logic [7:0] expTx, expBus;
        expTx  = (txExpQ.size() != 0) ? txExpQ[0] : 8'h00;
        expBus = (rxExpQ.size() != 0) ? rxExpQ[0] : 8'h00;
        checkVal("txValid", 8'(txValid), 8'(txExpQ.size() != 0));
        checkVal("txData", txData, expTx);
        checkVal("txFull", 8'(txFull), 8'(txExpQ.size() == DEPTH));
        checkVal("rxEmpty", 8'(rxEmpty), 8'(rxExpQ.size() == 0));
        checkVal("rxReady", 8'(rxReady), 8'(expRxEnable && rxExpQ.size() < DEPTH));
        checkVal("bus", busOut, expBus);
        checkVal("busNoe", 8'(busNoe), 8'(inNoe));
        checkVal("txOverflow", 8'(txOverflow), 8'(expTxOverflow));
        checkVal("rxUnderflow", 8'(rxUnderflow), 8'(expRxUnderflow));
    endtask

    // Apply the FIFO rules to the current inputs, advance one edge, then compare.
    task automatic step();
        bit txPopM, txPushM, rxPushM, rxPopM;
        txPopM  = (txExpQ.size() != 0) && txReady;
        txPushM = wrOut && ((txExpQ.size() < DEPTH) || txPopM);
        rxPushM = rxValid && expRxEnable && (rxExpQ.size() < DEPTH);
        rxPopM  = !inNoe && (rxExpQ.size() != 0);
        if (wrOut && !txPushM) expTxOverflow = 1'b1;
        if (!inNoe && rxExpQ.size() == 0) expRxUnderflow = 1'b1;
        if (txPopM) void'(txExpQ.pop_front());
        if (txPushM) txExpQ.push_back(bus);
        if (rxPopM) void'(rxExpQ.pop_front());
        if (rxPushM) rxExpQ.push_back(rxData);
        expRxEnable = 1'b1;
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    task automatic cyc(input logic wr, input logic [7:0] b, input logic tr,
                       input logic noe, input logic rv, input logic [7:0] rd);
        wrOut   = wr;
        bus     = b;
        txReady = tr;
        inNoe   = noe;
        rxValid = rv;
        rxData  = rd;
        step();
    endtask

    task automatic idleInputs();
        wrOut   = 1'b0;
        bus     = 8'h00;
        txReady = 1'b0;
        inNoe   = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
    endtask

    // Called just after a rising edge: reset lands mid-cycle and releases one edge later.
    task automatic asyncReset();
        #3;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutputs();
        checkVal("rxReadyDuringReset", 8'(rxReady), 8'h00);
        idleInputs();
        @(posedge clk);
        #1;
        checkOutputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutputs();
        reset = 1'b0;
        cyc(0, 8'h00, 0, 1, 0, 8'h00);
        checkVal("rxReadyAfterRelease", 8'(rxReady), 8'h01);

        // Three writes held in the TX FIFO, then drained in order.
        cyc(1, 8'h11, 0, 1, 0, 8'h00);
        cyc(1, 8'h22, 0, 1, 0, 8'h00);
        cyc(1, 8'h33, 0, 1, 0, 8'h00);
        checkVal("txHead11", txData, 8'h11);
        cyc(0, 8'h00, 1, 1, 0, 8'h00);
        checkVal("txHead22", txData, 8'h22);
        cyc(0, 8'h00, 1, 1, 0, 8'h00);
        checkVal("txHead33", txData, 8'h33);
        cyc(0, 8'h00, 1, 1, 0, 8'h00);
        checkVal("txDrained", 8'(txValid), 8'h00);

        // Overfill TX, then a write on a full FIFO with a simultaneous pop.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 8'hA0 + 8'(i), 0, 1, 0, 8'h00);
            if (i == 3) checkVal("txFullAfter4", 8'(txFull), 8'h01);
        end
        checkVal("txOverflowSet", 8'(txOverflow), 8'h01);
        cyc(1, 8'hB0, 1, 1, 0, 8'h00);
        checkVal("txFullKept", 8'(txFull), 8'h01);
        checkVal("txHeadA1", txData, 8'hA1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 1, 0, 8'h00);

        // Two RX bytes read back over two input strobes.
        cyc(0, 8'h00, 0, 1, 1, 8'h5A);
        cyc(0, 8'h00, 0, 1, 1, 8'hC3);
        checkVal("rxReadyKept", 8'(rxReady), 8'h01);
        checkVal("bus5A", busOut, 8'h5A);
        cyc(0, 8'h00, 0, 0, 0, 8'h00);
        checkVal("busC3", busOut, 8'hC3);
        cyc(0, 8'h00, 0, 0, 0, 8'h00);
        checkVal("rxEmptyAfterReads", 8'(rxEmpty), 8'h01);

        // Read on empty RX while a byte arrives: underflow, byte still stored.
        cyc(0, 8'h00, 0, 0, 1, 8'h77);
        checkVal("rxUnderflowSet", 8'(rxUnderflow), 8'h01);
        checkVal("bus77", busOut, 8'h77);
        cyc(0, 8'h00, 0, 0, 0, 8'h00);

        // Fill RX and hit it with an asynchronous reset.
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1, 1, 8'h40 + 8'(i));
        checkVal("rxFullReady", 8'(rxReady), 8'h00);
        asyncReset();
        cyc(0, 8'h00, 0, 1, 0, 8'h00);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                asyncReset();
            end else begin
                cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/io_port.md
# io_port

Byte-wide I/O peripheral that services the control unit's output and input strobes. When `i_ctrlWrOut` is asserted, the byte on the CPU data bus is captured into a transmit FIFO, which an external consumer drains over valid/ready. Received bytes from an external producer are buffered in a receive FIFO, and the head byte is driven onto the CPU data bus while `i_ctrlInNoe` is low. Sticky error flags report bytes dropped on a full transmit FIFO and reads from an empty receive FIFO.

## Interface
- `DEPTH`, default 4: entries per FIFO; power of two, 2..16.
- `i_clk`  in  1  system clock; all state updates on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_bus`  in  8  CPU data bus value; sampled on WrOut.
- `o_bus`  out  8  RX FIFO head; 0x00 when RX FIFO is empty.
- `o_busNoe`  out  1  active-low bus drive enable; equals `i_ctrlInNoe` (combinational).
- `i_ctrlWrOut`  in  1  active-high; push `i_bus` into TX FIFO at this edge.
- `i_ctrlInNoe`  in  1  active-low; drive head onto bus, pop RX FIFO at this edge.
- `o_txData`  out  8  TX FIFO head; 0x00 when `o_txValid`=0.
- `o_txValid`  out  1  TX FIFO non-empty.
- `i_txReady`  in  1  consumer accepts head when `o_txValid & i_txReady`.
- `i_rxData`  in  8  producer byte.
- `i_rxValid`  in  1  producer offers `i_rxData`.
- `o_rxReady`  out  1  RX FIFO not full, and not in reset.
- `o_txFull`  out  1  TX count == DEPTH.
- `o_rxEmpty`  out  1  RX count == 0.
- `o_txOverflow`  out  1  sticky; a WrOut byte was dropped.
- `o_rxUnderflow`  out  1  sticky; InNoe read while RX FIFO empty.

## Operation
- Each FIFO has a read pointer, a write pointer, and a count, all width log2(DEPTH)+1. Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- TX push: when `i_ctrlWrOut`=1, accept if count<DEPTH, or if a TX pop occurs at the same edge. Otherwise drop the byte and set `o_txOverflow`.
- TX pop: when `o_txValid & i_txReady`, advance the read pointer.
  - Simultaneous push and pop leaves count unchanged.
  - If count was DEPTH, the push is still accepted.
- RX push: when `i_rxValid & o_rxReady`, write `i_rxData` and advance the write pointer.
- RX pop: on each rising edge with `i_ctrlInNoe`=0.
  - If count>0, advance the read pointer.
  - If count==0, leave the pointers unchanged and set `o_rxUnderflow`; `o_bus` reads 0x00.
  - No fall-through: a byte pushed at edge N cannot be popped at edge N. Empty RX with a simultaneous push and InNoe read gives underflow and accepts the push (count becomes 1).
- Simultaneous RX push and pop with count>0 leaves count unchanged.
- Sticky flags clear only on reset.
- Halt does not affect this block; the FIFOs keep draining and filling.

## Timing
- Reset (async assert) clears pointers, counts and flags. Reset values of all outputs:
  - `o_bus`=0x00, `o_txData`=0x00
  - `o_txValid`=0, `o_rxReady`=0 (1 from the first cycle after reset release)
  - `o_txFull`=0, `o_rxEmpty`=1
  - `o_txOverflow`=0, `o_rxUnderflow`=0
  - `o_busNoe` follows `i_ctrlInNoe`
- Reset mid-transfer discards all FIFO contents. No partial handshake survives.
- Write latency: a byte pushed at edge N appears on `o_txData` with `o_txValid`=1 after edge N (one cycle).
- Receive latency: a byte accepted at edge N appears on `o_bus` after edge N; it can be popped at edge N+1 at the earliest.
- `o_bus` and `o_txData` are combinational reads of FIFO storage at the read pointer.
- Status outputs derive from the registered counts and reflect the state after the last edge.
- The control unit asserts strobes for one cycle per micro-step. A strobe held for k edges pushes or pops k times.

## Test plan
- Reset with DEPTH=4 → `o_rxEmpty`=1, `o_txValid`=0, `o_rxReady`=1 after release, `o_bus`=0x00, both flags 0.
- Pulse WrOut with bus=0x11, 0x22, 0x33 while `i_txReady`=0, then raise `i_txReady` → `o_txData` sequence is 0x11, 0x22, 0x33, then `o_txValid`=0.
- With `i_txReady`=0, do 5 WrOut writes (0xA0..0xA4) → `o_txFull`=1 after the 4th, 0xA4 dropped, `o_txOverflow`=1.
  - Full plus WrOut of 0xB0 with `i_txReady`=1 at the same edge → 0xB0 accepted, `o_txFull` stays 1, no new overflow.
- Producer sends 0x5A, 0xC3 → `o_rxReady` stays 1; InNoe reads on two edges yield `o_bus`=0x5A, then 0xC3, then `o_rxEmpty`=1.
- InNoe read on empty RX at the same edge as `i_rxValid`=1 with 0x77 → `o_rxUnderflow`=1, count=1, `o_bus`=0x77 next cycle.
- Fill RX with 4 bytes, assert async reset mid-cycle → all counts 0 immediately, `o_rxReady`=0 during reset, FIFO contents lost.
